// File: rtl/reduce_tap_pkg.sv
// Shared types and constants for the reducer result tap and the reducer core.
package reduce_tap_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } tap_state_e;

    localparam int CORE_WORD_W   = 130;
    localparam int CORE_DONE_BIT = 129;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tap_fifo.sv
// Registered synchronous FIFO; a push is visible on dat_o one cycle later, no fall-through.
// A push while full is accepted only if a pop happens in the same cycle.
module tap_fifo
    import reduce_tap_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_dat_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        dat_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero when empty so the idle output is clean after reset.
    assign dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/reduce_result_tap.sv
// Taps a field of the reducer state word into a small FIFO, stops at the done flag,
// drains, halts, and reports the run length in cycles.
module reduce_result_tap
    import reduce_tap_pkg::*;
#(
    parameter int WORD_W    = CORE_WORD_W,
    parameter int FIELD_LO  = 0,
    parameter int FIELD_W   = 1,
    parameter int DONE_BIT  = CORE_DONE_BIT,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 32,
    parameter int ON_CHANGE = 0
) (
    input  logic               system1000,
    input  logic               system1000_rst,
    input  logic [WORD_W-1:0]  core_word,
    input  logic               core_valid,
    output logic [FIELD_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow,
    output logic               halted,
    output logic [CNT_W-1:0]   cycles
);

    localparam int AW = clog2(DEPTH);

    tap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FIELD_W-1:0] last_q, last_d;
    logic             last_vld_q, last_vld_d;
    logic             ovf_q, ovf_d;

    logic [FIELD_W-1:0] field;
    logic             in_run, capture, done_hit, pop;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic [FIELD_W-1:0] fifo_dat;
    logic             unused_word_bits;

    // Only the field and the done flag matter; the rest of the word is ignored.
    assign unused_word_bits = ^core_word;

    assign field    = core_word[FIELD_LO +: FIELD_W];
    assign in_run   = (state_q == ST_RUN);
    assign capture  = in_run && core_valid &&
                      ((ON_CHANGE == 0) || !last_vld_q || (field != last_q));
    assign done_hit = in_run && core_valid && core_word[DONE_BIT];
    assign pop      = out_valid && out_ready;

    tap_fifo #(
        .WIDTH (FIELD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (system1000),
        .rst_i      (system1000_rst),
        .push_i     (capture),
        .push_dat_i (field),
        .pop_i      (pop),
        .dat_o      (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // Filter history advances on every capture, even one the FIFO drops.
    always_comb begin
        last_d     = capture ? field : last_q;
        last_vld_d = last_vld_q || capture;
        ovf_d      = ovf_q || (capture && fifo_full && !pop);
        cnt_d      = (in_run && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (done_hit) state_d = ST_DRAIN;
            ST_DRAIN:  if ((fifo_count == '0) && !capture) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        out_valid = !fifo_empty && (state_q != ST_HALTED);
        out_data  = fifo_dat;
        halted    = (state_q == ST_HALTED);
        overflow  = ovf_q;
        cycles    = cnt_q;
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule
